duty_ramp_ctrl: RTL and testbench

- Soft-start and reversal sequencer that sits directly upstream of the variable-speed PWM stage.
- Takes a commanded duty (from switches or a host) and a commanded direction.
- Produces the slew-limited duty word and the direction bit that the PWM stage compares against its free-running counter.
- Guarantees the motor never reverses under load: duty is ramped to zero, held for a dead time, then direction flips and duty ramps back up.

---
 rtl/duty_ramp_ctrl.sv | 114 +++++++++++
 tb/tb_duty_ramp_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp_ctrl.sv
// Soft-start / reversal sequencer ahead of the PWM stage: slew-limits duty and
// only flips direction after ramping to zero and waiting out a dead time.
module duty_ramp_ctrl #(
   parameter int WIDTH      = 12,
   parameter int STEP       = 16,
   parameter int TICK_DIV   = 5000,
   parameter int DEAD_TICKS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] target_duty,
   input  logic             target_dir,
   output logic [WIDTH-1:0] duty,
   output logic             dir,
   output logic             busy,
   output logic             at_target
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
   localparam logic [WIDTH:0]  STEP_W   = (WIDTH+1)'(STEP);
   localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0]   DEAD_LAST = DW'(DEAD_TICKS - 1);

   typedef enum logic [1:0] {RUN, DECEL, DEAD} state_t;

   state_t           state;
   logic             enable_q;
   logic [WIDTH-1:0] tgt_q;
   logic             tdir_q;
   logic [PW-1:0]    prescaler;
   logic [DW-1:0]    dead_cnt;
   logic [WIDTH-1:0] duty_reg;
   logic             dir_reg;
   logic             at_target_reg;
   logic             tick;
   logic [WIDTH-1:0] eff;

   assign tick      = (prescaler == PRE_LAST);
   assign eff       = enable_q ? tgt_q : '0;
   assign duty      = duty_reg;
   assign dir       = dir_reg;
   assign at_target = at_target_reg;
   assign busy      = ~at_target_reg;

   // One step toward goal, computed with a spare bit so it cannot wrap.
   function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                             input logic [WIDTH-1:0] goal);
      logic [WIDTH:0] c;
      logic [WIDTH:0] g;
      logic [WIDTH:0] s;
      c = {1'b0, cur};
      g = {1'b0, goal};
      s = cur;
      if (c < g)
         s = (g - c > STEP_W) ? (c + STEP_W) : g;
      else if (c > g)
         s = (c - g > STEP_W) ? (c - STEP_W) : g;
      return s[WIDTH-1:0];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= RUN;
         enable_q      <= 1'b0;
         tgt_q         <= '0;
         tdir_q        <= 1'b0;
         prescaler     <= '0;
         dead_cnt      <= '0;
         duty_reg      <= '0;
         dir_reg       <= 1'b0;
         at_target_reg <= 1'b1;
      end else begin
         enable_q      <= enable;
         tgt_q         <= target_duty;
         tdir_q        <= target_dir;
         prescaler     <= tick ? '0 : prescaler + 1'b1;
         at_target_reg <= (state == RUN) && (duty_reg == eff) && (dir_reg == tdir_q);
         if (tick) begin
            case (state)
               RUN: begin
                  if (tdir_q != dir_reg)
                     state <= DECEL;
                  else
                     duty_reg <= slew(duty_reg, eff);
               end
               DECEL: begin
                  if (tdir_q == dir_reg) begin
                     state <= RUN;
                  end else if (duty_reg == '0) begin
                     state    <= DEAD;
                     dead_cnt <= '0;
                  end else begin
                     duty_reg <= slew(duty_reg, '0);
                  end
               end
               DEAD: begin
                  duty_reg <= '0;
                  // A reverted command lands here too: dir simply reloads its old value.
                  if (dead_cnt == DEAD_LAST) begin
                     dir_reg <= tdir_q;
                     state   <= RUN;
                  end else begin
                     dead_cnt <= dead_cnt + 1'b1;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl with a fast tick (TICK_DIV=4, DEAD_TICKS=3).
module tb_duty_ramp_ctrl;

   localparam int W = 12;

   logic         clk;
   logic         reset;
   logic         enable;
   logic [W-1:0] target_duty;
   logic         target_dir;
   logic [W-1:0] duty;
   logic         dir;
   logic         busy;
   logic         at_target;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic         dir_prev  = 1'b0;
   logic [W-1:0] duty_prev = '0;

   duty_ramp_ctrl #(
      .WIDTH(W), .STEP(16), .TICK_DIV(4), .DEAD_TICKS(3)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .target_duty(target_duty),
      .target_dir(target_dir), .duty(duty), .dir(dir), .busy(busy),
      .at_target(at_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side cycle count since reset release; ticks land on multiples of 4.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Direction may only change while duty is, and was, zero.
   always @(negedge clk) begin
      if (reset && (dir !== dir_prev)) begin
         checks = checks + 1;
         assert (duty === '0 && duty_prev === '0) else begin
            errors = errors + 1;
            $error("FAIL dir_change_at_nonzero_duty: observed duty=%0d prev=%0d required 0", duty, duty_prev);
         end
      end
      dir_prev  <= dir;
      duty_prev <= duty;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      do begin
         @(posedge clk);
         #1;
      end while (cyc % 4 != 0);
   endtask

   initial begin
      int up[7]    = '{16, 32, 48, 64, 80, 96, 100};
      int down[4]  = '{84, 68, 52, 40};
      int rev_d[11] = '{40, 24, 8, 0, 0, 0, 0, 0, 16, 32, 40};
      int rev_r[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      int drop[4]  = '{24, 8, 0, 0};
      int back[3]  = '{16, 32, 40};

      reset = 1'b0; enable = 1'b0; target_duty = '0; target_dir = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_duty", 32'(duty), 0);
      check("reset_dir", 32'(dir), 0);
      check("reset_at_target", 32'(at_target), 1);
      check("reset_busy", 32'(busy), 0);

      enable = 1'b1; target_duty = 12'd100;
      @(negedge clk);
      reset = 1'b1;

      foreach (up[i]) begin
         wait_tick();
         $display("ramp_up tick %0d: duty=%0d dir=%0d", i, duty, dir);
         check("ramp_up_duty", 32'(duty), 32'(up[i]));
         check("ramp_up_dir", 32'(dir), 0);
      end
      check("ramp_up_at_target_lag", 32'(at_target), 0);
      @(posedge clk); #1;
      check("ramp_up_at_target", 32'(at_target), 1);
      check("ramp_up_busy", 32'(busy), 0);

      target_duty = 12'd40;
      foreach (down[i]) begin
         wait_tick();
         $display("ramp_down tick %0d: duty=%0d", i, duty);
         check("ramp_down_duty", 32'(duty), 32'(down[i]));
      end
      wait_tick();
      check("ramp_down_hold", 32'(duty), 40);
      check("ramp_down_at_target", 32'(at_target), 1);

      // Reversal request withdrawn while decelerating.
      target_dir = 1'b1;
      wait_tick();
      check("abort_enter_decel", 32'(duty), 40);
      check("abort_busy", 32'(busy), 1);
      wait_tick();
      check("abort_decel_step", 32'(duty), 24);
      target_dir = 1'b0;
      wait_tick();
      check("abort_back_to_run", 32'(duty), 24);
      wait_tick();
      check("abort_reramp", 32'(duty), 40);
      check("abort_dir", 32'(dir), 0);
      wait_tick();
      check("abort_at_target", 32'(at_target), 1);
      $display("abort: duty=%0d dir=%0d at_target=%0d", duty, dir, at_target);

      target_dir = 1'b1;
      foreach (rev_d[i]) begin
         wait_tick();
         $display("reverse tick %0d: duty=%0d dir=%0d busy=%0d", i, duty, dir, busy);
         check("reverse_duty", 32'(duty), 32'(rev_d[i]));
         check("reverse_dir", 32'(dir), 32'(rev_r[i]));
         check("reverse_busy", 32'(busy), 1);
      end
      wait_tick();
      check("reverse_at_target", 32'(at_target), 1);

      enable = 1'b0;
      foreach (drop[i]) begin
         wait_tick();
         $display("enable_drop tick %0d: duty=%0d dir=%0d", i, duty, dir);
         check("drop_duty", 32'(duty), 32'(drop[i]));
         check("drop_dir", 32'(dir), 1);
      end
      check("drop_at_target", 32'(at_target), 1);

      enable = 1'b1;
      foreach (back[i]) begin
         wait_tick();
         $display("enable_return tick %0d: duty=%0d", i, duty);
         check("return_duty", 32'(duty), 32'(back[i]));
      end

      // 40 + 16*253 = 4088, then the final partial step to 4090.
      target_duty = 12'd4090;
      repeat (254) wait_tick();
      check("full_scale_approach", 32'(duty), 4090);
      target_duty = 12'd4095;
      wait_tick();
      check("full_scale_step", 32'(duty), 4095);
      wait_tick();
      check("full_scale_hold", 32'(duty), 4095);
      check("full_scale_at_target", 32'(at_target), 1);
      $display("full_scale: duty=%0d", duty);

      target_duty = '0;
      wait_tick();
      check("mid_ramp_down", 32'(duty), 4079);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset_duty", 32'(duty), 0);
      check("async_reset_dir", 32'(dir), 0);
      check("async_reset_at_target", 32'(at_target), 1);
      check("async_reset_busy", 32'(busy), 0);
      $display("async reset: duty=%0d dir=%0d at_target=%0d", duty, dir, at_target);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
